// File: rtl/ariane_pkg.sv
// Shared types and helpers for the CVA6 HPDcache fence/flush sequencer.
package ariane_pkg;

   // Sequencer states: wait for request, drain stores, flush dcache,
   // pulse icache flush, signal completion.
   typedef enum logic [2:0] {
      FF_IDLE   = 3'd0,
      FF_DRAIN  = 3'd1,
      FF_FLUSH  = 3'd2,
      FF_ICACHE = 3'd3,
      FF_DONE   = 3'd4
   } fence_flush_state_e;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/store_outstanding_cnt.sv
// Saturating up/down counter of dcache stores that were issued but not yet
// acknowledged. Issue and done in the same cycle cancel out.
module store_outstanding_cnt
   import ariane_pkg::*;
#(
   parameter int unsigned MaxCnt = 7
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         issue_i,
   input  logic                         done_i,
   output logic [cnt_width(MaxCnt)-1:0] count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned CntW = cnt_width(MaxCnt);
   localparam logic [CntW-1:0] MaxVal = CntW'(MaxCnt);

   logic [CntW-1:0] count_d, count_q;
   logic            full, empty;

   assign full    = (count_q == MaxVal);
   assign empty   = (count_q == '0);
   assign count_o = count_q;
   assign full_o  = full;
   assign empty_o = empty;

   // Next count: step up or down, never past either end.
   always_comb begin
      // NOTE: default assignment first so every path drives count_d and no latch is inferred.
      count_d = count_q;
      if (issue_i && !done_i && !full) begin
         count_d = count_q + CntW'(1);
      end else if (done_i && !issue_i && !empty) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
         count_q <= count_d;
      end
   end

   // An issue into a full counter or a completion with nothing in flight is
   // an LSU protocol error; the counter saturates instead of wrapping.
   a_no_issue_when_full : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(issue_i && !done_i && full));
   a_no_done_when_empty : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(done_i && !issue_i && empty));

endmodule

// File: rtl/cva6_hpdcache_fence_flush.sv
// Fence sequencer between the CVA6 commit stage and the HPDcache flush port.
// Drains the store buffer and in-flight stores, then requests a dcache
// write-back flush and, for fence.i, an icache flush.
// Optional watchdog on the FLUSH state: define CVA6_FENCE_FLUSH_TIMEOUT_EN.
module cva6_hpdcache_fence_flush
   import ariane_pkg::*;
#(
   parameter int unsigned MaxOutstandingStores = 7,
   parameter logic        FlushOnFence         = 1'b1,
   parameter int unsigned TimeoutCycles        = 4096
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       fence_req_i,
   input  logic                                       fence_i_req_i,
   output logic                                       fence_ack_o,
   output logic                                       busy_o,
   input  logic                                       stbuf_empty_i,
   input  logic                                       store_issue_i,
   input  logic                                       store_done_i,
   output logic [cnt_width(MaxOutstandingStores)-1:0] stores_pending_o,
   output logic                                       stall_store_o,
   output logic                                       dcache_flush_o,
   input  logic                                       dcache_flush_ack_i,
   output logic                                       icache_flush_o,
   output logic                                       flush_timeout_o
);

   fence_flush_state_e state_d, state_q;
   logic               is_fence_i_d, is_fence_i_q;
   logic               cnt_empty;

   store_outstanding_cnt #(
      .MaxCnt (MaxOutstandingStores)
   ) i_store_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .issue_i (store_issue_i),
      .done_i  (store_done_i),
      .count_o (stores_pending_o),
      .full_o  (stall_store_o),
      .empty_o (cnt_empty)
   );

   // Next-state logic; requests are only accepted in IDLE, and fence.i wins
   // when both request lines are high together.
   always_comb begin
      state_d      = state_q;
      is_fence_i_d = is_fence_i_q;
      unique case (state_q)
         FF_IDLE: begin
            if (fence_req_i || fence_i_req_i) begin
               state_d      = FF_DRAIN;
               is_fence_i_d = fence_i_req_i;
            end
         end
         FF_DRAIN: begin
            if (stbuf_empty_i && cnt_empty) begin
               state_d = (is_fence_i_q || FlushOnFence) ? FF_FLUSH : FF_DONE;
            end
         end
         FF_FLUSH: begin
            if (dcache_flush_ack_i) begin
               state_d = is_fence_i_q ? FF_ICACHE : FF_DONE;
            end
         end
         FF_ICACHE: state_d = FF_DONE;
         FF_DONE:   state_d = FF_IDLE;
         default:   state_d = FF_IDLE;
      endcase
   end

   // State and request-type registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FF_IDLE;
         is_fence_i_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         is_fence_i_q <= is_fence_i_d;
      end
   end

   // Moore outputs decoded from the registered state only.
   assign busy_o         = (state_q != FF_IDLE);
   assign dcache_flush_o = (state_q == FF_FLUSH);
   assign icache_flush_o = (state_q == FF_ICACHE);
   assign fence_ack_o    = (state_q == FF_DONE);

`ifdef CVA6_FENCE_FLUSH_TIMEOUT_EN
   // TimeoutCycles is expected to be at least 1.
   localparam int unsigned TmoW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   logic [TmoW-1:0] tmo_cnt_d, tmo_cnt_q;
   logic            flush_timeout_d, flush_timeout_q;

   // Watchdog: count FLUSH cycles, raise a sticky flag after TimeoutCycles of them.
   always_comb begin
      tmo_cnt_d       = '0;
      flush_timeout_d = flush_timeout_q;
      if (state_q == FF_FLUSH) begin
         if (tmo_cnt_q == TmoLast) begin
            tmo_cnt_d       = tmo_cnt_q;
            flush_timeout_d = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
         end
      end
   end

   // Watchdog registers; the flag clears only on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q       <= '0;
         flush_timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q       <= tmo_cnt_d;
         flush_timeout_q <= flush_timeout_d;
      end
   end

   assign flush_timeout_o = flush_timeout_q;
`else
   assign flush_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cva6_hpdcache_fence_flush.sv
// Directed bench for cva6_hpdcache_fence_flush. Instance dut_a flushes on a
// plain fence, dut_n does not; both share all inputs.
module tb_cva6_hpdcache_fence_flush;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic fence_req_i = 1'b0, fence_i_req_i = 1'b0;
   logic stbuf_empty_i = 1'b1, store_issue_i = 1'b0, store_done_i = 1'b0;
   logic dcache_flush_ack_i = 1'b0;

   logic       ack_a, busy_a, stall_a, dflush_a, iflush_a, tmo_a;
   logic       ack_n, busy_n, stall_n, dflush_n, iflush_n, tmo_n;
   logic [2:0] pend_a, pend_n;
   logic [3:0] vec_a, vec_n;

   int checks = 0;
   int errors = 0;

   assign vec_a = {busy_a, dflush_a, iflush_a, ack_a};
   assign vec_n = {busy_n, dflush_n, iflush_n, ack_n};

   always #5 clk_i = ~clk_i;

   cva6_hpdcache_fence_flush #(
      .MaxOutstandingStores (7),
      .FlushOnFence         (1'b1),
      .TimeoutCycles        (16)
   ) dut_a (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .fence_req_i        (fence_req_i),
      .fence_i_req_i      (fence_i_req_i),
      .fence_ack_o        (ack_a),
      .busy_o             (busy_a),
      .stbuf_empty_i      (stbuf_empty_i),
      .store_issue_i      (store_issue_i),
      .store_done_i       (store_done_i),
      .stores_pending_o   (pend_a),
      .stall_store_o      (stall_a),
      .dcache_flush_o     (dflush_a),
      .dcache_flush_ack_i (dcache_flush_ack_i),
      .icache_flush_o     (iflush_a),
      .flush_timeout_o    (tmo_a)
   );

   cva6_hpdcache_fence_flush #(
      .MaxOutstandingStores (7),
      .FlushOnFence         (1'b0),
      .TimeoutCycles        (16)
   ) dut_n (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .fence_req_i        (fence_req_i),
      .fence_i_req_i      (fence_i_req_i),
      .fence_ack_o        (ack_n),
      .busy_o             (busy_n),
      .stbuf_empty_i      (stbuf_empty_i),
      .store_issue_i      (store_issue_i),
      .store_done_i       (store_done_i),
      .stores_pending_o   (pend_n),
      .stall_store_o      (stall_n),
      .dcache_flush_o     (dflush_n),
      .dcache_flush_ack_i (dcache_flush_ack_i),
      .icache_flush_o     (iflush_n),
      .flush_timeout_o    (tmo_n)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      step();
      step();
      checks++;
      if ({vec_a, vec_n} !== 8'h00) begin
         errors++;
         $display("FAIL reset_fsm_outputs got %b want 00000000", {vec_a, vec_n});
      end
      checks++;
      if ({pend_a, stall_a, tmo_a, pend_n, stall_n, tmo_n} !== 10'b0) begin
         errors++;
         $display("FAIL reset_counters got %b want 0000000000",
                  {pend_a, stall_a, tmo_a, pend_n, stall_n, tmo_n});
      end
      rst_ni = 1'b1;
      step();
      checks++;
      if ({vec_a, vec_n} !== 8'h00) begin
         errors++;
         $display("FAIL after_reset_idle got %b want 00000000", {vec_a, vec_n});
      end
   endtask

   // Plain fence, nothing pending: dut_a flushes (ack at cycle 2), dut_n acks in cycle 2.
   task automatic test_fence();
      logic [3:0] exp_a, exp_n;
      fence_req_i = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         step();
         fence_req_i        = 1'b0;
         dcache_flush_ack_i = (t == 2);
         case (t)
            1:       begin exp_a = 4'b1000; exp_n = 4'b1000; end
            2:       begin exp_a = 4'b1100; exp_n = 4'b1001; end
            3:       begin exp_a = 4'b1001; exp_n = 4'b0000; end
            default: begin exp_a = 4'b0000; exp_n = 4'b0000; end
         endcase
         checks++;
         if (vec_a !== exp_a) begin
            errors++;
            $display("FAIL fence_flush c%0d got %b want %b", t, vec_a, exp_a);
         end
         checks++;
         if (vec_n !== exp_n) begin
            errors++;
            $display("FAIL fence_noflush c%0d got %b want %b", t, vec_n, exp_n);
         end
      end
      dcache_flush_ack_i = 1'b0;
   endtask

   // fence.i with 3 stores in flight, done at cycles 4/6/8, flush ack at 12.
   task automatic test_fence_i_drain();
      logic [3:0] exp_v;
      logic [2:0] exp_p;
      store_issue_i = 1'b1;
      step();
      step();
      step();
      store_issue_i = 1'b0;
      checks++;
      if (pend_a !== 3'd3) begin
         errors++;
         $display("FAIL preload_pending got %0d want 3", pend_a);
      end
      fence_i_req_i = 1'b1;
      for (int t = 1; t <= 15; t++) begin
         step();
         fence_i_req_i      = 1'b0;
         store_done_i       = (t == 4) || (t == 6) || (t == 8);
         dcache_flush_ack_i = (t == 12);
         if (t <= 9)       exp_v = 4'b1000;
         else if (t <= 12) exp_v = 4'b1100;
         else if (t == 13) exp_v = 4'b1010;
         else if (t == 14) exp_v = 4'b1001;
         else              exp_v = 4'b0000;
         if (t <= 4)      exp_p = 3'd3;
         else if (t <= 6) exp_p = 3'd2;
         else if (t <= 8) exp_p = 3'd1;
         else             exp_p = 3'd0;
         checks++;
         if ({vec_a, pend_a} !== {exp_v, exp_p}) begin
            errors++;
            $display("FAIL fence_i_drain c%0d got %b/%0d want %b/%0d",
                     t, vec_a, pend_a, exp_v, exp_p);
         end
      end
      store_done_i       = 1'b0;
      dcache_flush_ack_i = 1'b0;
   endtask

   // Fill to 7, hold with simultaneous issue+done, then drain back to 0.
   task automatic test_store_stall();
      logic [2:0] exp_p;
      store_issue_i = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         step();
         store_issue_i = (t <= 8);
         store_done_i  = (t >= 7) && (t <= 15);
         if (t <= 7)      exp_p = 3'(t);
         else if (t <= 9) exp_p = 3'd7;
         else             exp_p = 3'(16 - t);
         checks++;
         if ({pend_a, stall_a, busy_a} !== {exp_p, (exp_p == 3'd7), 1'b0}) begin
            errors++;
            $display("FAIL store_stall c%0d got pend=%0d stall=%b busy=%b want pend=%0d stall=%b busy=0",
                     t, pend_a, stall_a, busy_a, exp_p, (exp_p == 3'd7));
         end
      end
      store_issue_i = 1'b0;
      store_done_i  = 1'b0;
   endtask

   // Both requests at once (fence.i wins); a new fence during DRAIN is ignored.
   task automatic test_dual_req();
      logic [3:0] exp_v;
      int         n_icache = 0;
      int         n_ack    = 0;
      stbuf_empty_i = 1'b0;
      fence_req_i   = 1'b1;
      fence_i_req_i = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         step();
         fence_req_i        = (t == 2);
         fence_i_req_i      = 1'b0;
         stbuf_empty_i      = (t >= 3);
         dcache_flush_ack_i = (t == 5);
         if (t <= 3)      exp_v = 4'b1000;
         else if (t <= 5) exp_v = 4'b1100;
         else if (t == 6) exp_v = 4'b1010;
         else if (t == 7) exp_v = 4'b1001;
         else             exp_v = 4'b0000;
         if (iflush_a) n_icache++;
         if (ack_a)    n_ack++;
         checks++;
         if (vec_a !== exp_v) begin
            errors++;
            $display("FAIL dual_req c%0d got %b want %b", t, vec_a, exp_v);
         end
      end
      dcache_flush_ack_i = 1'b0;
      stbuf_empty_i      = 1'b1;
      checks++;
      if (n_icache != 1 || n_ack != 1) begin
         errors++;
         $display("FAIL dual_req_pulses got icache=%0d ack=%0d want icache=1 ack=1", n_icache, n_ack);
      end
   endtask

   // Reset while in FLUSH drops the request at once, no ack; a new fence then completes.
   task automatic test_reset_mid_flush();
      logic [3:0] exp_a;
      fence_req_i = 1'b1;
      step();
      fence_req_i = 1'b0;
      step();
      checks++;
      if (vec_a !== 4'b1100) begin
         errors++;
         $display("FAIL pre_reset_flush got %b want 1100", vec_a);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (vec_a !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_drop got %b want 0000", vec_a);
      end
      for (int t = 0; t < 2; t++) begin
         step();
         checks++;
         if (vec_a !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold c%0d got %b want 0000", t, vec_a);
         end
      end
      rst_ni = 1'b1;
      step();
      fence_req_i = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         step();
         fence_req_i        = 1'b0;
         dcache_flush_ack_i = (t == 2);
         case (t)
            1:       exp_a = 4'b1000;
            2:       exp_a = 4'b1100;
            3:       exp_a = 4'b1001;
            default: exp_a = 4'b0000;
         endcase
         checks++;
         if (vec_a !== exp_a) begin
            errors++;
            $display("FAIL post_reset_fence c%0d got %b want %b", t, vec_a, exp_a);
         end
      end
      dcache_flush_ack_i = 1'b0;
   endtask

   // Ack withheld: FLUSH spans cycles 2..20; the watchdog (if built) fires in cycle 18.
   task automatic test_timeout();
      logic [3:0] exp_v;
      logic       exp_t;
      fence_req_i = 1'b1;
      for (int t = 1; t <= 24; t++) begin
         step();
         fence_req_i        = 1'b0;
         dcache_flush_ack_i = (t == 20);
         if (t == 1)       exp_v = 4'b1000;
         else if (t <= 20) exp_v = 4'b1100;
         else if (t == 21) exp_v = 4'b1001;
         else              exp_v = 4'b0000;
`ifdef CVA6_FENCE_FLUSH_TIMEOUT_EN
         exp_t = (t >= 18);
`else
         exp_t = 1'b0;
`endif
         checks++;
         if ({vec_a, tmo_a} !== {exp_v, exp_t}) begin
            errors++;
            $display("FAIL timeout c%0d got %b/%b want %b/%b", t, vec_a, tmo_a, exp_v, exp_t);
         end
      end
      dcache_flush_ack_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fence();
      test_fence_i_drain();
      test_store_stall();
      test_dual_req();
      test_reset_mid_flush();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
